bnn_layer_seq: RTL and testbench
================================

Name: bnn_layer_seq

Overview:
Layer sequencer for the BNN core. On `start` it walks every (neuron, input-word) pair of one fully connected binary layer and issues one read per cycle to the weight memory and the activation buffer. It XNOR-popcount-accumulates the returned words, thresholds each neuron's sum, and packs the results into a NEURONS-bit output register. It sits between the top-level I/O glue and the weight and activation storage.

Parameters:
- IN_WORDS, 4, number of WORD_W-bit words per input activation vector.
- NEURONS, 8, number of neurons (output bits) in the layer.
- WORD_W, 8, memory word width in bits.
- Derived: TOTAL = NEURONS*IN_WORDS.
- Derived: PC_W = clog2(IN_WORDS*WORD_W+1), which is 6 at the defaults.
- Derived: WA_W = clog2(TOTAL); AA_W = max(1, clog2(IN_WORDS)).

Ports:
- clk  in  1  single clock; all logic is rising-edge.
- rst_n  in  1  synchronous, active-low reset.
- start  in  1  begin a layer pass; accepted only in IDLE.
- abort  in  1  cancel an in-progress pass.
- thresh  in  PC_W  neuron firing threshold; sampled on an accepted start.
- w_rd  out  1  read strobe shared by the weight memory and the activation buffer.
- w_addr  out  WA_W  weight address = n*IN_WORDS + j.
- act_addr  out  AA_W  activation word address = j.
- w_data  in  WORD_W  weight word; valid in the cycle after w_rd.
- act_data  in  WORD_W  activation word; valid in the cycle after w_rd.
- busy  out  1  high in RUN and DRAIN.
- done  out  1  one-cycle pulse when out_bits is final.
- out_bits  out  NEURONS  bit n = neuron n fired.

Behaviour:
- Reset (rst_n low at a rising edge) forces:
  - state = IDLE;
  - w_rd, w_addr, act_addr, busy, done, out_bits = 0;
  - internal accumulator and counters = 0.
  - Reset overrides start and abort and applies mid-pass.
- All outputs are registered.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - start=1 latches thresh, clears out_bits and the accumulator, sets n=j=0, w_rd=1, and moves to RUN.
  - abort is ignored.
- RUN:
  - One read is issued per cycle; j increments and wraps at IN_WORDS-1 with n incrementing on the wrap.
  - After the read of address TOTAL-1 is issued, the next edge sets w_rd=0 and moves to DRAIN.
- DRAIN: lasts exactly one cycle, then moves to DONE.
- DONE: done=1 and busy=0 for exactly one cycle, then IDLE.
- start is ignored in RUN, DRAIN and DONE; start in the cycle after DONE is accepted.
- Datapath (one-cycle read latency):
  - At each edge following a cycle with w_rd=1, compute pc = popcount(~(w_data ^ act_data)), range 0..WORD_W.
  - For j < IN_WORDS-1: acc <= acc + pc.
  - For j = IN_WORDS-1: sum = acc + pc; out_bits[n] <= (sum >= thresh_latched), unsigned compare; acc <= 0.
  - The pipelined (n, j) tag travels with the read strobe.
- Timing: with the start accept at edge 0, reads are issued in cycles 1..TOTAL, the last data is consumed at edge TOTAL+1, and done is high in the cycle after edge TOTAL+1.
  - Defaults: TOTAL=32, so done is high 33 edges after the start edge.
- Width rules:
  - acc is PC_W bits and never overflows; the maximum is IN_WORDS*WORD_W.
  - thresh=0 means every neuron fires.
  - thresh > IN_WORDS*WORD_W means no neuron fires.
- abort in RUN or DRAIN:
  - next edge: state=IDLE, w_rd=0, busy=0;
  - in-flight data is discarded and done is never pulsed;
  - out_bits keeps its partial value until the next accepted start clears it.
- out_bits is stable outside RUN and DRAIN. Bits update one at a time during a pass.

Test Plan:
- Match: w_data == act_data for all words, thresh=32 → out_bits=8'hFF; done high exactly one cycle, 33 edges after start; busy low in the done cycle.
- Anti-match: w_data = ~act_data, thresh=1 → out_bits=8'h00; repeat with thresh=0 → 8'hFF; thresh=33 with full match → 8'h00.
- Graded: weights chosen so neuron n matching-bit count = 4n, thresh=16 → out_bits=8'hF0; also check the w_addr sequence is 0..31 and act_addr cycles 0,1,2,3.
- Handshake: start held high throughout a pass → no restart mid-pass; exactly one done; a second pass starts on the edge after DONE; thresh changed mid-pass has no effect.
- Abort at the 10th RUN cycle → next cycle w_rd=0, busy=0; no done pulse; then a fresh start with full match and thresh=32 gives 8'hFF.
- Reset: rst_n low for one edge mid-RUN → all outputs 0 the following cycle; FSM in IDLE; a subsequent start runs normally.

Source files
------------

// File: rtl/bnn_layer_seq.sv
// Layer sequencer for one fully connected binary layer: walks every
// (neuron, input-word) pair, issues one weight/activation read per cycle,
// XNOR-popcount-accumulates the returned words and thresholds each neuron
// into a packed output register.
module bnn_layer_seq #(
    parameter int IN_WORDS = 4,
    parameter int NEURONS  = 8,
    parameter int WORD_W   = 8,
    localparam int TOTAL   = NEURONS * IN_WORDS,
    localparam int PC_W    = $clog2(IN_WORDS * WORD_W + 1),
    localparam int WA_W    = (TOTAL > 1) ? $clog2(TOTAL) : 1,
    localparam int AA_W    = (IN_WORDS > 1) ? $clog2(IN_WORDS) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               abort,
    input  logic [PC_W-1:0]    thresh,
    output logic               w_rd,
    output logic [WA_W-1:0]    w_addr,
    output logic [AA_W-1:0]    act_addr,
    input  logic [WORD_W-1:0]  w_data,
    input  logic [WORD_W-1:0]  act_data,
    output logic               busy,
    output logic               done,
    output logic [NEURONS-1:0] out_bits
);

    localparam int N_W = (NEURONS > 1) ? $clog2(NEURONS) : 1;
    localparam logic [WA_W-1:0] LAST_ADDR = WA_W'(TOTAL - 1);
    localparam logic [AA_W-1:0] J_LAST    = AA_W'(IN_WORDS - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t          state, next_state;
    logic            accept, abort_hit;
    logic [N_W-1:0]  n_cnt, n_q;
    logic [AA_W-1:0] j_q;
    logic            rd_q;
    logic [PC_W-1:0] acc, thresh_q, pc, sum;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    // Next-state decode; also flags start acceptance and a live abort.
    always_comb begin
        next_state = state;
        accept     = 1'b0;
        abort_hit  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = RUN;
                    accept     = 1'b1;
                end
            end
            RUN: begin
                if (abort) begin
                    next_state = IDLE;
                    abort_hit  = 1'b1;
                end else if (w_addr == LAST_ADDR) begin
                    next_state = DRAIN;
                end
            end
            DRAIN: begin
                if (abort) begin
                    next_state = IDLE;
                    abort_hit  = 1'b1;
                end else begin
                    next_state = DONE;
                end
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // XNOR-popcount of the returned word pair and the running neuron sum.
    always_comb begin
        pc = '0;
        for (int unsigned i = 0; i < WORD_W; i++) begin
            pc = pc + PC_W'(~(w_data[i] ^ act_data[i]));
        end
        sum = acc + pc;
    end

    // Read strobe, status flags and address counters; the flags are registered
    // decodes of next_state so they line up with the state they describe.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            w_rd     <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            w_addr   <= '0;
            act_addr <= '0;
            n_cnt    <= '0;
        end else begin
            w_rd <= (next_state == RUN);
            busy <= (next_state == RUN) || (next_state == DRAIN);
            done <= (next_state == DONE);
            if (accept) begin
                w_addr   <= '0;
                act_addr <= '0;
                n_cnt    <= '0;
            end else if (state == RUN && next_state == RUN) begin
                w_addr <= w_addr + WA_W'(1);
                if (act_addr == J_LAST) begin
                    act_addr <= '0;
                    n_cnt    <= n_cnt + N_W'(1);
                end else begin
                    act_addr <= act_addr + AA_W'(1);
                end
            end
        end
    end

    // Datapath: the (n, j) tag follows the read strobe by one cycle so each
    // returned word is accumulated against the neuron that requested it; an
    // abort drops both the word arriving now and the one still in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_q     <= 1'b0;
            n_q      <= '0;
            j_q      <= '0;
            acc      <= '0;
            thresh_q <= '0;
            out_bits <= '0;
        end else begin
            rd_q <= w_rd & ~abort_hit;
            n_q  <= n_cnt;
            j_q  <= act_addr;
            if (accept) begin
                thresh_q <= thresh;
                acc      <= '0;
                out_bits <= '0;
            end else if (rd_q && !abort_hit) begin
                if (j_q == J_LAST) begin
                    out_bits[n_q] <= (sum >= thresh_q);
                    acc           <= '0;
                end else begin
                    acc <= sum;
                end
            end
        end
    end

endmodule

// File: tb/tb_bnn_layer_seq.sv
// Self-checking bench for bnn_layer_seq: table-driven layer passes with a
// scoreboard of expected out_bits, plus hand-written handshake, abort and
// mid-pass reset sequences.
module tb_bnn_layer_seq;

    logic       clk = 1'b0;
    logic       rst_n, start, abort;
    logic [5:0] thresh;
    logic       w_rd;
    logic [4:0] w_addr;
    logic [1:0] act_addr;
    logic [7:0] w_data = 8'h00;
    logic [7:0] act_data = 8'h00;
    logic       busy, done;
    logic [7:0] out_bits;

    logic [7:0] wmem [32];
    logic [7:0] amem [4];
    logic [7:0] sb_q [$];

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int         kind;
        logic [5:0] th;
        logic [7:0] exp;
        bit         use_model;
    } vec_t;

    vec_t vecs [7];

    bnn_layer_seq #(
        .IN_WORDS(4),
        .NEURONS (8),
        .WORD_W  (8)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .abort   (abort),
        .thresh  (thresh),
        .w_rd    (w_rd),
        .w_addr  (w_addr),
        .act_addr(act_addr),
        .w_data  (w_data),
        .act_data(act_data),
        .busy    (busy),
        .done    (done),
        .out_bits(out_bits)
    );

    always #5 clk = ~clk;

    // Memory model with one-cycle read latency; junk when not reading.
    always @(posedge clk) begin
        if (w_rd === 1'b1) begin
            w_data   <= wmem[w_addr];
            act_data <= amem[act_addr];
        end else begin
            w_data   <= 8'h5A;
            act_data <= 8'h00;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // 0: match, 1: anti-match, 2: graded (neuron n matches 4n bits), 3: random
    task automatic load(input int kind);
        logic [7:0] base [4];
        base[0] = 8'h3C; base[1] = 8'hA5; base[2] = 8'h0F; base[3] = 8'h96;
        for (int j = 0; j < 4; j++) begin
            case (kind)
                0, 1:    amem[j] = base[j];
                2:       amem[j] = 8'h00;
                default: amem[j] = 8'($urandom);
            endcase
        end
        for (int n = 0; n < 8; n++) begin
            for (int j = 0; j < 4; j++) begin
                case (kind)
                    0:       wmem[n*4+j] = amem[j];
                    1:       wmem[n*4+j] = ~amem[j];
                    2:       wmem[n*4+j] = 8'hFF << n;
                    default: wmem[n*4+j] = 8'($urandom);
                endcase
            end
        end
    endtask

    function automatic logic [7:0] model(input logic [5:0] th);
        logic [7:0] m;
        m = '0;
        for (int n = 0; n < 8; n++) begin
            int s;
            s = 0;
            for (int j = 0; j < 4; j++) s += $countones(~(wmem[n*4+j] ^ amem[j]));
            m[n] = (s >= int'(th));
        end
        return m;
    endfunction

    // Called at #1 after the start-accept edge; follows the pass to done.
    task automatic wait_done();
        int edges, rd_idx, addr_err;
        logic [7:0] exp;
        edges = 0; rd_idx = 0; addr_err = 0;
        while (edges < 100) begin
            if (w_rd === 1'b1) begin
                if (w_addr !== 5'(rd_idx) || act_addr !== 2'(rd_idx % 4)) addr_err++;
                rd_idx++;
            end
            if (done === 1'b1) break;
            @(posedge clk); #1;
            edges++;
        end
        chk("done_seen", 32'(done), 32'd1);
        chk("addr_seq_errors", 32'(addr_err), 32'd0);
        chk("read_count", 32'(rd_idx), 32'd32);
        chk("done_latency", 32'(edges), 32'd33);
        chk("busy_in_done", 32'(busy), 32'd0);
        if (sb_q.size() == 0) begin
            chk("scoreboard_nonempty", 32'd0, 32'd1);
        end else begin
            exp = sb_q.pop_front();
            chk("out_bits", 32'(out_bits), 32'(exp));
        end
    endtask

    task automatic run_pass(input logic [5:0] th, input logic [7:0] exp);
        sb_q.push_back(exp);
        @(negedge clk);
        start  = 1'b1;
        thresh = th;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done();
        @(posedge clk); #1;
        chk("done_one_cycle", 32'(done), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int dc;
        vecs[0] = '{0, 6'd32, 8'hFF, 1'b0};
        vecs[1] = '{1, 6'd1,  8'h00, 1'b0};
        vecs[2] = '{1, 6'd0,  8'hFF, 1'b0};
        vecs[3] = '{0, 6'd33, 8'h00, 1'b0};
        vecs[4] = '{2, 6'd16, 8'hF0, 1'b0};
        vecs[5] = '{2, 6'd28, 8'h80, 1'b0};
        vecs[6] = '{3, 6'd16, 8'h00, 1'b1};

        rst_n = 1'b0; start = 1'b0; abort = 1'b0; thresh = '0;
        load(0);
        repeat (2) @(posedge clk);
        #1;
        chk("reset_w_rd", 32'(w_rd), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_out_bits", 32'(out_bits), 32'd0);
        chk("reset_w_addr", 32'(w_addr), 32'd0);
        chk("reset_act_addr", 32'(act_addr), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) begin
            load(vecs[i].kind);
            run_pass(vecs[i].th, vecs[i].use_model ? model(vecs[i].th) : vecs[i].exp);
        end

        // Handshake: start held high, thresh changed after the accept.
        load(0);
        sb_q.push_back(8'hFF);
        @(negedge clk);
        start = 1'b1; thresh = 6'd32;
        @(posedge clk); #1;
        thresh = 6'd33;
        wait_done();
        @(posedge clk); #1;
        chk("hold_no_restart_busy", 32'(busy), 32'd0);
        chk("hold_done_one_cycle", 32'(done), 32'd0);
        @(posedge clk); #1;
        chk("hold_restart_busy", 32'(busy), 32'd1);
        chk("hold_restart_w_rd", 32'(w_rd), 32'd1);
        start = 1'b0;
        sb_q.push_back(8'h00);
        wait_done();
        @(posedge clk); #1;

        // Abort in the 10th RUN cycle.
        load(0);
        @(negedge clk);
        start = 1'b1; thresh = 6'd32;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) begin
            @(posedge clk); #1;
        end
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("abort_w_rd", 32'(w_rd), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_partial_bits", 32'(out_bits), 32'h03);
        dc = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done === 1'b1) dc++;
        end
        chk("abort_no_done", 32'(dc), 32'd0);
        chk("abort_bits_stable", 32'(out_bits), 32'h03);
        run_pass(6'd32, 8'hFF);

        // Reset mid-RUN.
        @(negedge clk);
        start = 1'b1; thresh = 6'd32;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (12) begin
            @(posedge clk); #1;
        end
        chk("pre_reset_bits", 32'(out_bits), 32'h03);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("midrst_w_rd", 32'(w_rd), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_out_bits", 32'(out_bits), 32'd0);
        chk("midrst_w_addr", 32'(w_addr), 32'd0);
        chk("midrst_act_addr", 32'(act_addr), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_reset_idle_busy", 32'(busy), 32'd0);
        chk("post_reset_idle_w_rd", 32'(w_rd), 32'd0);
        load(2);
        run_pass(6'd16, 8'hF0);

        chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
